// File: rtl/sparc_seq_pkg.sv
// Shared PC-sequencer definitions: nPC mux source codes, sequencer states, reset nPC.
package sparc_seq_pkg;

    localparam logic [1:0] MUX_NPC_ADD4   = 2'b00;
    localparam logic [1:0] MUX_NPC_ADD8   = 2'b01;
    localparam logic [1:0] MUX_NPC_ALU    = 2'b10;
    localparam logic [1:0] MUX_NPC_CONST4 = 2'b11;

    localparam logic [31:0] RESET_NPC_DEF = 32'h4;

    typedef enum logic [1:0] {
        ST_RST   = 2'b00,
        ST_RUN   = 2'b01,
        ST_DSLOT = 2'b10,
        ST_TRAP  = 2'b11
    } seq_state_e;

endpackage

// File: rtl/npc_next_calc.sv
// Combinational next pc/npc/mux_npc/state/squash selector for the sequencer.
// Trap entry is present only when NPC_SEQ_TRAP_EN is defined.
module npc_next_calc
    import sparc_seq_pkg::*;
(
    input  seq_state_e  state_i,
    input  logic        squash_i,
    input  logic [31:0] npc_i,
    input  logic        br_valid_i,
    input  logic        br_taken_i,
    input  logic        br_always_i,
    input  logic        annul_i,
    input  logic [31:0] target_i,
    input  logic        trap_req_i,
    input  logic [31:0] tbr_addr_i,
    output seq_state_e  state_o,
    output logic [31:0] pc_o,
    output logic [31:0] npc_o,
    output logic [1:0]  mux_npc_o,
    output logic        squash_o
);

    logic trap_take;

`ifdef NPC_SEQ_TRAP_EN
    assign trap_take = trap_req_i;
`else
    logic unused_trap;
    assign trap_take   = 1'b0;
    assign unused_trap = ^{trap_req_i, tbr_addr_i};
`endif

    // An annulled slot ignores CTI inputs and just flows sequentially.
    logic cti_live;
    assign cti_live = ~squash_i & br_valid_i;

    always_comb begin
        state_o   = ST_RUN;
        pc_o      = npc_i;
        npc_o     = npc_i + 32'd4;
        mux_npc_o = MUX_NPC_ADD4;
        squash_o  = 1'b0;
        if (state_i == ST_RUN || state_i == ST_DSLOT) begin
            if (trap_take) begin
                state_o = ST_TRAP;
                pc_o    = tbr_addr_i;
                npc_o   = tbr_addr_i + 32'd4;
            end else if (cti_live && br_taken_i) begin
                state_o   = ST_DSLOT;
                npc_o     = target_i;
                mux_npc_o = MUX_NPC_ALU;
                squash_o  = annul_i & br_always_i;
            end else if (cti_live && annul_i) begin
                pc_o      = npc_i + 32'd4;
                npc_o     = npc_i + 32'd8;
                mux_npc_o = MUX_NPC_ADD8;
            end
        end
    end

endmodule

// File: rtl/npc_sequencer.sv
// SPARC PC/nPC register pair and nPC mux select; next-state logic lives in npc_next_calc.
// Trap entry (trap_req/tbr_addr) is honored only when NPC_SEQ_TRAP_EN is defined.
module npc_sequencer
    import sparc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] RESET_NPC = RESET_NPC_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        adv,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        br_always,
    input  logic        annul,
    input  logic [31:0] target,
    input  logic        trap_req,
    input  logic [31:0] tbr_addr,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic [1:0]  mux_npc,
    output logic        squash,
    output logic        in_dslot
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic [1:0]  mux_q, mux_d;
    logic        squash_q, squash_d;

    npc_next_calc u_calc (
        .state_i     (state_q),
        .squash_i    (squash_q),
        .npc_i       (npc_q),
        .br_valid_i  (br_valid),
        .br_taken_i  (br_taken),
        .br_always_i (br_always),
        .annul_i     (annul),
        .target_i    (target),
        .trap_req_i  (trap_req),
        .tbr_addr_i  (tbr_addr),
        .state_o     (state_d),
        .pc_o        (pc_d),
        .npc_o       (npc_d),
        .mux_npc_o   (mux_d),
        .squash_o    (squash_d)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_RST;
            pc_q     <= RESET_PC;
            npc_q    <= RESET_NPC;
            mux_q    <= MUX_NPC_CONST4;
            squash_q <= 1'b0;
        end else if (adv) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            npc_q    <= npc_d;
            mux_q    <= mux_d;
            squash_q <= squash_d;
        end
    end

    assign pc       = pc_q;
    assign npc      = npc_q;
    assign mux_npc  = mux_q;
    assign squash   = squash_q;
    assign in_dslot = (state_q == ST_DSLOT);

endmodule

// File: tb/tb_npc_sequencer.sv
// Self-checking bench for npc_sequencer: directed scenarios with literal expectations
// plus randomized traffic against a behavioural model; honors NPC_SEQ_TRAP_EN.
module tb_npc_sequencer;

`ifdef NPC_SEQ_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        adv = 1'b0;
    logic        br_valid = 1'b0, br_taken = 1'b0, br_always = 1'b0, annul = 1'b0;
    logic [31:0] target = '0;
    logic        trap_req = 1'b0;
    logic [31:0] tbr_addr = '0;
    logic [31:0] pc, npc;
    logic [1:0]  mux_npc;
    logic        squash, in_dslot;

    int tests = 0;
    int fails = 0;

    npc_sequencer dut (
        .Clk(Clk), .Reset(Reset), .adv(adv),
        .br_valid(br_valid), .br_taken(br_taken), .br_always(br_always), .annul(annul),
        .target(target), .trap_req(trap_req), .tbr_addr(tbr_addr),
        .pc(pc), .npc(npc), .mux_npc(mux_npc), .squash(squash), .in_dslot(in_dslot)
    );

    always #5 Clk = ~Clk;

    // Behavioural model: architectural PC pair plus "just reset" / "just trapped" flags.
    logic [31:0] m_pc, m_npc, m_old;
    logic [1:0]  m_mux;
    logic        m_sq, m_ds, m_fresh, m_trapped, m_valid = 1'b0;

    always @(posedge Clk) begin
        if (Reset) begin
            m_pc = 32'h0; m_npc = 32'h4; m_mux = 2'b11;
            m_sq = 1'b0; m_ds = 1'b0; m_fresh = 1'b1; m_trapped = 1'b0; m_valid = 1'b1;
        end else if (m_valid && adv) begin
            m_old = m_npc;
            if (!m_fresh && !m_trapped && TRAP_EN && trap_req) begin
                m_pc = tbr_addr; m_npc = tbr_addr + 32'd4; m_mux = 2'b00;
                m_sq = 1'b0; m_ds = 1'b0; m_trapped = 1'b1;
            end else if (!m_fresh && !m_trapped && !m_sq && br_valid && br_taken) begin
                m_pc = m_old; m_npc = target; m_mux = 2'b10;
                m_sq = annul & br_always; m_ds = 1'b1;
            end else if (!m_fresh && !m_trapped && !m_sq && br_valid && annul) begin
                m_pc = m_old + 32'd4; m_npc = m_old + 32'd8; m_mux = 2'b01;
                m_sq = 1'b0; m_ds = 1'b0;
            end else begin
                m_pc = m_old; m_npc = m_old + 32'd4; m_mux = 2'b00;
                m_sq = 1'b0; m_ds = 1'b0; m_trapped = 1'b0;
            end
            m_fresh = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (m_valid) begin
            chk("model_pc", pc, m_pc);
            chk("model_npc", npc, m_npc);
            chk("model_mux", {30'd0, mux_npc}, {30'd0, m_mux});
            chk("model_squash", {31'd0, squash}, {31'd0, m_sq});
            chk("model_dslot", {31'd0, in_dslot}, {31'd0, m_ds});
        end
    end

    task automatic cyc(input bit r, input bit a, input bit bv, input bit bt, input bit ba,
                       input bit an, input logic [31:0] tg, input bit tr, input logic [31:0] tb);
        Reset = r; adv = a; br_valid = bv; br_taken = bt; br_always = ba; annul = an;
        target = tg; trap_req = tr; tbr_addr = tb;
        @(posedge Clk);
        #1;
    endtask

    task automatic seq1();
        cyc(0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic go10();
        cyc(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        repeat (4) seq1();
    endtask

    task automatic pin(input string n, input logic [31:0] epc, input logic [31:0] enpc,
                       input logic [1:0] emux, input bit esq, input bit eds);
        chk({n, "_pc"}, pc, epc);
        chk({n, "_npc"}, npc, enpc);
        chk({n, "_mux"}, {30'd0, mux_npc}, {30'd0, emux});
        chk({n, "_sq"}, {31'd0, squash}, {31'd0, esq});
        chk({n, "_ds"}, {31'd0, in_dslot}, {31'd0, eds});
    endtask

    initial begin
        // Reset then sequential flow
        cyc(1, 1, 1, 1, 1, 1, 32'h40, 1, 32'h80);
        pin("reset", 32'h0, 32'h4, 2'b11, 0, 0);
        seq1(); pin("seq1", 32'h4, 32'h8, 2'b00, 0, 0);
        seq1(); pin("seq2", 32'h8, 32'hC, 2'b00, 0, 0);
        seq1(); pin("seq3", 32'hC, 32'h10, 2'b00, 0, 0);

        // Taken bne, no annul
        go10(); pin("at10", 32'h10, 32'h14, 2'b00, 0, 0);
        cyc(0, 1, 1, 1, 0, 0, 32'h100, 0, 32'h0); pin("bne_t", 32'h14, 32'h100, 2'b10, 0, 1);
        seq1(); pin("bne_tgt", 32'h100, 32'h104, 2'b00, 0, 0);

        // Untaken bne,a skips the slot
        go10();
        cyc(0, 1, 1, 0, 0, 1, 32'h100, 0, 32'h0); pin("bne_a_nt", 32'h18, 32'h1C, 2'b01, 0, 0);

        // ba,a squashes the slot; CTI during squashed cycle ignored
        go10();
        cyc(0, 1, 1, 1, 1, 1, 32'h200, 0, 32'h0); pin("ba_a", 32'h14, 32'h200, 2'b10, 1, 1);
        cyc(0, 1, 1, 1, 1, 0, 32'h990, 0, 32'h0); pin("ba_a_tgt", 32'h200, 32'h204, 2'b00, 0, 0);

        // Trap in delay slot
        go10();
        cyc(0, 1, 1, 1, 0, 0, 32'h100, 0, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 32'h0, 1, 32'h800);
        if (TRAP_EN) pin("trap", 32'h800, 32'h804, 2'b00, 0, 0);
        else         pin("notrap", 32'h100, 32'h104, 2'b00, 0, 0);
        cyc(0, 1, 1, 1, 0, 0, 32'h500, 1, 32'h900);
        if (TRAP_EN) pin("trap_exit", 32'h804, 32'h808, 2'b00, 0, 0);
        else         pin("notrap2", 32'h104, 32'h500, 2'b10, 0, 1);

        // Stall mid-DSLOT, then reset while stalled
        go10();
        cyc(0, 1, 1, 1, 0, 0, 32'h100, 0, 32'h0);
        repeat (3) begin
            cyc(0, 0, 1, 1, 1, 1, 32'h700, 1, 32'h800);
            pin("stall", 32'h14, 32'h100, 2'b10, 0, 1);
        end
        cyc(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0); pin("rst_stall", 32'h0, 32'h4, 2'b11, 0, 0);

        // Wrap-around and DCTI couple
        go10();
        cyc(0, 1, 1, 1, 0, 0, 32'hFFFF_FFFC, 0, 32'h0);
        seq1(); pin("wrap", 32'hFFFF_FFFC, 32'h0, 2'b00, 0, 0);
        seq1(); pin("wrap2", 32'h0, 32'h4, 2'b00, 0, 0);
        go10();
        cyc(0, 1, 1, 1, 0, 0, 32'h100, 0, 32'h0);
        cyc(0, 1, 1, 1, 1, 0, 32'h300, 0, 32'h0); pin("dcti", 32'h100, 32'h300, 2'b10, 0, 1);
        seq1(); pin("dcti2", 32'h300, 32'h304, 2'b00, 0, 0);

        // Randomized traffic, checked every cycle by the model compare process
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] tg;
            tg = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 2) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), tg, ($urandom_range(0, 15) == 0),
                $urandom & 32'hFFFF_FFF0);
        end
        @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
